// File: rtl/pix_layer_sched.sv
// Per-pixel layer scheduler: NUM_RECT double-buffered rectangles, fixed priority (layer 0 highest).
// Optional macro LAYER_BORDER_EN draws the winning rectangle's outline in palette index 7.
module pix_layer_sched #(
  parameter int NUM_RECT = 4,
  parameter int CW       = 12,
  parameter int IDXW     = 4
) (
  input  logic            pixclk_i,
  input  logic            rst_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [2:0]      cfg_sel_i,
  input  logic [2:0]      cfg_field_i,
  input  logic [CW-1:0]   cfg_data_i,
  input  logic [CW-1:0]   x_i,
  input  logic [CW-1:0]   y_i,
  input  logic            DrawArea_i,
  input  logic            vSync_i,
  output logic [IDXW-1:0] pix_idx_o,
  output logic            pix_de_o,
  output logic [2:0]      pix_layer_o,
  output logic            pix_hit_o,
  output logic            commit_pending_o
);

  typedef struct packed {
    logic [CW-1:0]   x0;
    logic [CW-1:0]   x1;
    logic [CW-1:0]   y0;
    logic [CW-1:0]   y1;
    logic [IDXW-1:0] col;
    logic            en;
  } rect_t;

  rect_t           shadow_q [NUM_RECT];
  rect_t           active_q [NUM_RECT];
  logic            vsync_q;
  logic            commitPending_q, commitPending_d;
  logic            commitEvt;

  logic [NUM_RECT-1:0] hit_d, s1Hit_q;
  logic [NUM_RECT-1:0] edge_d, s1Edge_q;
  logic [IDXW-1:0]     s1Col_q [NUM_RECT];
  logic                s1De_q;

  logic [IDXW-1:0] pixIdx_d, pixIdx_q;
  logic [2:0]      pixLayer_d, pixLayer_q;
  logic            pixHit_d, pixHit_q, pixDe_q;

  // The shadow->active copy happens on the vSync rise; stalling config that cycle avoids a race.
  assign commitEvt        = vSync_i & ~vsync_q & commitPending_q;
  assign cfg_ready_o      = ~commitEvt;
  assign commit_pending_o = commitPending_q;

  always_comb begin
    commitPending_d = commitPending_q;
    if (commitEvt)
      commitPending_d = 1'b0;
    else if (cfg_valid_i && cfg_field_i == 3'd7)
      commitPending_d = 1'b1;
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      vsync_q         <= 1'b0;
      commitPending_q <= 1'b0;
    end else begin
      vsync_q         <= vSync_i;
      commitPending_q <= commitPending_d;
      if (commitEvt) begin
        for (int i = 0; i < NUM_RECT; i++) active_q[i] <= shadow_q[i];
      end else if (cfg_valid_i) begin
        for (int i = 0; i < NUM_RECT; i++) begin
          if (cfg_sel_i == 3'(i)) begin
            case (cfg_field_i)
              3'd0: shadow_q[i].x0  <= cfg_data_i;
              3'd1: shadow_q[i].x1  <= cfg_data_i;
              3'd2: shadow_q[i].y0  <= cfg_data_i;
              3'd3: shadow_q[i].y1  <= cfg_data_i;
              3'd4: shadow_q[i].col <= cfg_data_i[IDXW-1:0];
              3'd5: shadow_q[i].en  <= cfg_data_i[0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Inverted bounds (x0>x1 or y0>y1) fall out of the inclusive compares as "never hits".
  always_comb begin
    hit_d  = '0;
    edge_d = '0;
    for (int i = 0; i < NUM_RECT; i++) begin
      hit_d[i] = active_q[i].en &&
                 x_i >= active_q[i].x0 && x_i <= active_q[i].x1 &&
                 y_i >= active_q[i].y0 && y_i <= active_q[i].y1;
`ifdef LAYER_BORDER_EN
      edge_d[i] = hit_d[i] && (x_i == active_q[i].x0 || x_i == active_q[i].x1 ||
                               y_i == active_q[i].y0 || y_i == active_q[i].y1);
`endif
    end
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Hit_q  <= '0;
      s1Edge_q <= '0;
      s1De_q   <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) s1Col_q[i] <= '0;
    end else begin
      s1Hit_q  <= hit_d;
      s1Edge_q <= edge_d;
      s1De_q   <= DrawArea_i;
      for (int i = 0; i < NUM_RECT; i++) s1Col_q[i] <= active_q[i].col;
    end
  end

  // Scanning from the lowest priority upward lets the highest-priority hit overwrite the rest.
  always_comb begin
    pixIdx_d   = '0;
    pixLayer_d = '0;
    pixHit_d   = 1'b0;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (s1Hit_q[i]) begin
        pixHit_d   = 1'b1;
        pixLayer_d = 3'(i);
        pixIdx_d   = s1Edge_q[i] ? IDXW'(7) : s1Col_q[i];
      end
    end
    if (!s1De_q) begin
      pixIdx_d   = '0;
      pixLayer_d = '0;
      pixHit_d   = 1'b0;
    end
  end

  always_ff @(posedge pixclk_i or posedge rst_i) begin
    if (rst_i) begin
      pixIdx_q   <= '0;
      pixLayer_q <= '0;
      pixHit_q   <= 1'b0;
      pixDe_q    <= 1'b0;
    end else begin
      pixIdx_q   <= pixIdx_d;
      pixLayer_q <= pixLayer_d;
      pixHit_q   <= pixHit_d;
      pixDe_q    <= s1De_q;
    end
  end

  assign pix_idx_o   = pixIdx_q;
  assign pix_layer_o = pixLayer_q;
  assign pix_hit_o   = pixHit_q;
  assign pix_de_o    = pixDe_q;

endmodule
